// File: rtl/rgb_axis_pkg.sv
// Shared types for the RGB pixel to AXI4-Stream packer.
// Beat layout, FSM states and drop counter width.
package rgb_axis_pkg;

  localparam int BEAT_W     = 32;
  localparam int DROP_CNT_W = 16;

  typedef enum logic {
    WAIT_SOF,
    ACTIVE
  } packer_state_t;

  typedef struct packed {
    logic              tuser;
    logic              tlast;
    logic [BEAT_W-1:0] tdata;
  } rgb_beat_t;

endpackage

// File: rtl/rgb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO of rgb_beat_t.
// full/empty come from the registered occupancy count.
module rgb_sync_fifo
  import rgb_axis_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  rgb_beat_t wdata,
  output rgb_beat_t rdata,
  output logic      full,
  output logic      empty,
  output logic [AW:0] level
);

  rgb_beat_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Storage has no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/rgb_axis_packer.sv
// Packs an RGB pixel stream into an AXI4-Stream master via a FIFO.
// Optional drop counter enabled by RGB_AXIS_DROP_CNT_EN.
module rgb_axis_packer
  import rgb_axis_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = 8,
  parameter int TDATA_W = 32
) (
  input  logic                     pixclk,
  input  logic                     resetn,
  input  logic                     valid,
  input  logic [DATA_W-1:0]        iRed,
  input  logic [DATA_W-1:0]        iGreen,
  input  logic [DATA_W-1:0]        iBlue,
  input  logic                     iSof,
  input  logic                     iEol,
  input  logic                     clr_ovf,
  input  logic                     m_axis_mm2s_tready,
  output logic                     m_axis_mm2s_tvalid,
  output logic [TDATA_W-1:0]       m_axis_mm2s_tdata,
  output logic                     m_axis_mm2s_tlast,
  output logic                     m_axis_mm2s_tuser,
  output logic                     ovf,
`ifdef RGB_AXIS_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]    drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]   fifo_level
);

  packer_state_t state;
  rgb_beat_t     wbeat;
  rgb_beat_t     rbeat;
  rgb_beat_t     obeat;
  logic          tvalid;
  logic          full;
  logic          empty;
  logic          accept;
  logic          want;
  logic          push;
  logic          pop;
  logic          drop;

  assign wbeat.tuser = iSof;
  assign wbeat.tlast = iEol;
  assign wbeat.tdata = BEAT_W'({iRed, iGreen, iBlue});

  // WAIT_SOF only lets the frame-start pixel through.
  assign accept = (state == ACTIVE) || iSof;
  assign want   = valid && accept;
  assign pop    = !empty && (!tvalid || m_axis_mm2s_tready);
  assign push   = want && (!full || pop);
  assign drop   = want && !push;

  rgb_sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (pixclk),
    .rst_n(resetn),
    .push (push),
    .pop  (pop),
    .wdata(wbeat),
    .rdata(rbeat),
    .full (full),
    .empty(empty),
    .level(fifo_level)
  );

  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      state <= WAIT_SOF;
    end else begin
      unique case (state)
        WAIT_SOF: if (valid && iSof) state <= ACTIVE;
        ACTIVE:   state <= ACTIVE;
        default:  state <= WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      tvalid <= 1'b0;
      obeat  <= '0;
    end else if (pop) begin
      tvalid <= 1'b1;
      obeat  <= rbeat;
    end else if (m_axis_mm2s_tready) begin
      tvalid <= 1'b0;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn)      ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

`ifdef RGB_AXIS_DROP_CNT_EN
  logic cnt_inc;
  assign cnt_inc = drop && (state == ACTIVE);

  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn)
      drop_cnt <= '0;
    else if (clr_ovf)
      drop_cnt <= '0;
    else if (cnt_inc && (drop_cnt != '1))
      drop_cnt <= drop_cnt + 1'b1;
  end
`endif

  assign m_axis_mm2s_tvalid = tvalid;
  assign m_axis_mm2s_tdata  = TDATA_W'(obeat.tdata);
  assign m_axis_mm2s_tlast  = obeat.tlast;
  assign m_axis_mm2s_tuser  = obeat.tuser;

endmodule

// File: tb/tb_rgb_axis_packer.sv
// Directed self-checking bench for rgb_axis_packer (DEPTH=16).
// Connects drop_cnt when RGB_AXIS_DROP_CNT_EN is defined.
module tb_rgb_axis_packer;

  logic        pixclk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  iRed = '0;
  logic [7:0]  iGreen = '0;
  logic [7:0]  iBlue = '0;
  logic        iSof = 1'b0;
  logic        iEol = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        tready = 1'b0;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tuser;
  logic        ovf;
  logic [4:0]  fifo_level;
`ifdef RGB_AXIS_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int passes = 0;

  rgb_axis_packer #(
    .DEPTH(16),
    .DATA_W(8),
    .TDATA_W(32)
  ) dut (
    .pixclk            (pixclk),
    .resetn            (resetn),
    .valid             (valid),
    .iRed              (iRed),
    .iGreen            (iGreen),
    .iBlue             (iBlue),
    .iSof              (iSof),
    .iEol              (iEol),
    .clr_ovf           (clr_ovf),
    .m_axis_mm2s_tready(tready),
    .m_axis_mm2s_tvalid(tvalid),
    .m_axis_mm2s_tdata (tdata),
    .m_axis_mm2s_tlast (tlast),
    .m_axis_mm2s_tuser (tuser),
    .ovf               (ovf),
`ifdef RGB_AXIS_DROP_CNT_EN
    .drop_cnt          (drop_cnt),
`endif
    .fifo_level        (fifo_level)
  );

  always #5 pixclk = ~pixclk;

  task automatic step();
    @(posedge pixclk);
    #1;
  endtask

  task automatic pix(input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b, input logic sof, input logic eol);
    valid = 1'b1;
    iRed = r;
    iGreen = g;
    iBlue = b;
    iSof = sof;
    iEol = eol;
  endtask

  task automatic idle();
    valid = 1'b0;
    iSof = 1'b0;
    iEol = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      valid = ~valid;
      iSof = 1'b1;
      step();
    end
    checks++; if (tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", tvalid); else passes++;
    checks++; if (tdata !== 32'h0) $display("FAIL rst_tdata: got %h want 0", tdata); else passes++;
    checks++; if (tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", tlast); else passes++;
    checks++; if (tuser !== 1'b0) $display("FAIL rst_tuser: got %b want 0", tuser); else passes++;
    checks++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf); else passes++;
    checks++; if (fifo_level !== 5'd0) $display("FAIL rst_level: got %0d want 0", fifo_level); else passes++;
    idle();
    resetn = 1'b1;
    step();
    pix(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    step();
    idle();
    step();
    step();
    checks++; if (tvalid !== 1'b0) $display("FAIL nosof_tvalid: got %b want 0", tvalid); else passes++;
    checks++; if (fifo_level !== 5'd0) $display("FAIL nosof_level: got %0d want 0", fifo_level); else passes++;
  endtask

  task automatic test_basic_line();
    logic [7:0]  r [4];
    logic [7:0]  g [4];
    logic [7:0]  b [4];
    logic [31:0] exp [4];
    r = '{8'h11, 8'h44, 8'h77, 8'hAA};
    g = '{8'h22, 8'h55, 8'h88, 8'hBB};
    b = '{8'h33, 8'h66, 8'h99, 8'hCC};
    exp = '{32'h00112233, 32'h00445566, 32'h00778899, 32'h00AABBCC};
    tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) pix(r[k], g[k], b[k], k == 0, k == 3);
      else idle();
      step();
      if (k == 0) begin
        checks++; if (tvalid !== 1'b0) $display("FAIL line_latency: got %b want 0", tvalid); else passes++;
      end else begin
        checks++; if (tvalid !== 1'b1) $display("FAIL line_tvalid%0d: got %b want 1", k-1, tvalid); else passes++;
        checks++; if (tdata !== exp[k-1]) $display("FAIL line_tdata%0d: got %h want %h", k-1, tdata, exp[k-1]); else passes++;
        checks++; if (tuser !== (k == 1)) $display("FAIL line_tuser%0d: got %b want %b", k-1, tuser, k == 1); else passes++;
        checks++; if (tlast !== (k == 4)) $display("FAIL line_tlast%0d: got %b want %b", k-1, tlast, k == 4); else passes++;
      end
    end
    step();
    checks++; if (tvalid !== 1'b0) $display("FAIL line_end_tvalid: got %b want 0", tvalid); else passes++;
  endtask

  task automatic test_backpressure();
    tready = 1'b0;
    pix(8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
    step();
    idle();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (tvalid !== 1'b1) $display("FAIL bp_tvalid%0d: got %b want 1", i, tvalid); else passes++;
      checks++; if (tdata !== 32'h00112233) $display("FAIL bp_tdata%0d: got %h want 00112233", i, tdata); else passes++;
      checks++; if (tuser !== 1'b1) $display("FAIL bp_tuser%0d: got %b want 1", i, tuser); else passes++;
      step();
    end
    tready = 1'b1;
    step();
    checks++; if (tvalid !== 1'b0) $display("FAIL bp_release: got %b want 0", tvalid); else passes++;
  endtask

  task automatic test_overflow();
    int n;
    logic [7:0]  v;
    logic [31:0] e;
    tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      v = 8'(i);
      pix(v, v + 8'h40, v + 8'h80, i == 0, 1'b0);
      step();
    end
    idle();
    step();
    checks++; if (fifo_level !== 5'd16) $display("FAIL ovf_level: got %0d want 16", fifo_level); else passes++;
    checks++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ovf); else passes++;
`ifdef RGB_AXIS_DROP_CNT_EN
    checks++; if (drop_cnt !== 16'd3) $display("FAIL ovf_dropcnt: got %0d want 3", drop_cnt); else passes++;
`endif
    tready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (tvalid) begin
        v = 8'(n);
        e = {8'h00, v, v + 8'h40, v + 8'h80};
        checks++; if (tdata !== e) $display("FAIL ovf_beat%0d: got %h want %h", n, tdata, e); else passes++;
        n++;
      end
      step();
    end
    checks++; if (n !== 17) $display("FAIL ovf_count: got %0d want 17", n); else passes++;
    checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else passes++;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf); else passes++;
`ifdef RGB_AXIS_DROP_CNT_EN
    checks++; if (drop_cnt !== 16'd0) $display("FAIL ovf_dropclr: got %0d want 0", drop_cnt); else passes++;
`endif
  endtask

  task automatic test_full_push_pop();
    tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      pix(8'(8'h30 + i), 8'h01, 8'h02, 1'b0, 1'b0);
      step();
    end
    idle();
    step();
    checks++; if (fifo_level !== 5'd16) $display("FAIL full_level: got %0d want 16", fifo_level); else passes++;
    checks++; if (ovf !== 1'b0) $display("FAIL full_ovf0: got %b want 0", ovf); else passes++;
    tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pix(8'h50, 8'h51, 8'h52, 1'b0, 1'b0);
      step();
      checks++; if (fifo_level !== 5'd16) $display("FAIL pp_level%0d: got %0d want 16", i, fifo_level); else passes++;
    end
    idle();
    checks++; if (ovf !== 1'b0) $display("FAIL pp_ovf: got %b want 0", ovf); else passes++;
    for (int i = 0; i < 25; i++) step();
    checks++; if (tvalid !== 1'b0) $display("FAIL pp_drain_tvalid: got %b want 0", tvalid); else passes++;
    checks++; if (fifo_level !== 5'd0) $display("FAIL pp_drain_level: got %0d want 0", fifo_level); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix(8'(8'h60 + i), 8'h61, 8'h62, i == 0, 1'b0);
      step();
    end
    idle();
    step();
    checks++; if (tvalid !== 1'b1) $display("FAIL mid_pre_tvalid: got %b want 1", tvalid); else passes++;
    #2 resetn = 1'b0;
    #1;
    checks++; if (tvalid !== 1'b0) $display("FAIL mid_tvalid: got %b want 0", tvalid); else passes++;
    checks++; if (tdata !== 32'h0) $display("FAIL mid_tdata: got %h want 0", tdata); else passes++;
    checks++; if (tuser !== 1'b0) $display("FAIL mid_tuser: got %b want 0", tuser); else passes++;
    checks++; if (fifo_level !== 5'd0) $display("FAIL mid_level: got %0d want 0", fifo_level); else passes++;
    step();
    resetn = 1'b1;
    tready = 1'b1;
    pix(8'h70, 8'h71, 8'h72, 1'b0, 1'b0);
    step();
    pix(8'h73, 8'h74, 8'h75, 1'b0, 1'b0);
    step();
    idle();
    step();
    step();
    checks++; if (tvalid !== 1'b0) $display("FAIL mid_discard: got %b want 0", tvalid); else passes++;
    pix(8'hDE, 8'hAD, 8'hBE, 1'b1, 1'b0);
    step();
    idle();
    n = 0;
    while (!tvalid && n < 10) begin
      step();
      n++;
    end
    checks++; if (tvalid !== 1'b1) $display("FAIL mid_timeout: got %b want 1", tvalid); else passes++;
    checks++; if (tdata !== 32'h00DEADBE) $display("FAIL mid_first_tdata: got %h want 00deadbe", tdata); else passes++;
    checks++; if (tuser !== 1'b1) $display("FAIL mid_first_tuser: got %b want 1", tuser); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
